// File: rtl/gardner_loop_nco.sv
// gardner_loop_nco: PI loop filter plus decrementing NCO for Gardner symbol timing recovery.
//
// Each timing-error sample passes through a proportional-integral filter. The filter's
// control word trims the step of an NCO that decrements once per interpolator sample.
// When the NCO underflows, the block registers a one-cycle symbol strobe together with
// the fractional interval mu.
//
// Optional build macro GARDNER_LOOP_INTEG_SAT_EN: when it is defined, the integrator and
// the control word saturate at the signed ACC_WIDTH limits. When it is undefined, both
// wrap modulo 2^ACC_WIDTH.
//
// Handshake: err_valid and sample_valid are valid-only qualifiers with no back-pressure.
// A high level means the accompanying data (or one interpolator sample) is consumed in
// that same cycle. Nothing is held or retried.
module gardner_loop_nco #(
  parameter int SYM_WIDTH = 1,
  parameter int INT_WIDTH = 1,
  parameter int DEC_WIDTH = 14,
  parameter int ACC_WIDTH = 20,
  parameter int NCO_WIDTH = 16,
  parameter int K1_SHIFT  = 4,
  parameter int K2_SHIFT  = 10,
  parameter logic [NCO_WIDTH-1:0] NOM_STEP = 16'h8000,
  parameter logic [NCO_WIDTH-1:0] ETA_INIT = 16'hFFFF,
  parameter int MU_SHIFT  = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           err_valid,
  input  logic signed [SYM_WIDTH+INT_WIDTH+DEC_WIDTH-1:0] err_data,
  input  logic                                           sample_valid,
  input  logic                                           loop_clr,
  output logic                                           strobe,
  output logic        [DEC_WIDTH-1:0]                    mu,
  output logic        [ACC_WIDTH-1:0]                    ctrl_word
);

  // Width of the step computation: the control word scaled into NCO units, plus one
  // guard bit so that adding NOM_STEP can never wrap before the clamp is applied.
  localparam int SW = ACC_WIDTH + NCO_WIDTH - DEC_WIDTH + 1;
  localparam int SH = NCO_WIDTH - DEC_WIDTH;
  localparam int MW = NCO_WIDTH + MU_SHIFT;

  localparam logic signed [SW-1:0] NOM_W    = SW'(NOM_STEP);
  localparam logic signed [SW-1:0] STEP_MIN = SW'(1);
  localparam logic signed [SW-1:0] STEP_MAX = SW'({NCO_WIDTH{1'b1}});

  // Filter-domain adder. It wraps by default and clamps when saturation is built in.
  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
`ifdef GARDNER_LOOP_INTEG_SAT_EN
    logic signed [ACC_WIDTH:0] s;
    s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      if (s[ACC_WIDTH]) return {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else              return {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    return s[ACC_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  logic signed [ACC_WIDTH-1:0] integ_q, integ_d;
  logic signed [ACC_WIDTH-1:0] ctrl_q, ctrl_d;
  logic        [NCO_WIDTH-1:0] eta_q, eta_d;
  logic        [DEC_WIDTH-1:0] mu_q, mu_d;
  logic                        strobe_q, strobe_d;

  logic signed [ACC_WIDTH-1:0] e_ext;
  logic signed [ACC_WIDTH-1:0] integ_n;
  logic signed [ACC_WIDTH-1:0] ctrl_n;
  logic signed [SW-1:0]        step_wide;
  logic        [NCO_WIDTH-1:0] step;
  logic                        underflow;
  logic        [MW-1:0]        eta_sh;
  logic                        mu_ovf;
  logic        [DEC_WIDTH-1:0] mu_new;

  assign e_ext = ACC_WIDTH'(err_data);

  // Loop filter: the integrator takes a 2^-K2 share of the error, and the output adds
  // a 2^-K1 proportional term. A clear takes priority over a new error sample.
  always_comb begin
    integ_n = acc_add(integ_q, e_ext >>> K2_SHIFT);
    ctrl_n  = acc_add(e_ext >>> K1_SHIFT, integ_n);
    integ_d = integ_q;
    ctrl_d  = ctrl_q;
    if (loop_clr) begin
      integ_d = '0;
      ctrl_d  = '0;
    end else if (err_valid) begin
      integ_d = integ_n;
      ctrl_d  = ctrl_n;
    end
  end

  // NCO step: nominal step plus the registered control word scaled to NCO units,
  // clamped so the step is never zero and never wraps past full scale.
  always_comb begin
    step_wide = NOM_W + ((SW'(ctrl_q)) <<< SH);
    if (step_wide < STEP_MIN)      step = STEP_MIN[NCO_WIDTH-1:0];
    else if (step_wide > STEP_MAX) step = STEP_MAX[NCO_WIDTH-1:0];
    else                           step = step_wide[NCO_WIDTH-1:0];
  end

  // Underflow detection and mu extraction use the pre-update eta. Mu saturates when
  // the MU_SHIFT scaling pushes a set bit off the top of the NCO word.
  always_comb begin
    underflow = (eta_q < step);
    eta_sh    = MW'(eta_q) << MU_SHIFT;
    mu_ovf    = (eta_sh >> NCO_WIDTH) != '0;
    mu_new    = mu_ovf ? '1 : DEC_WIDTH'(eta_sh >> SH);
  end

  // NCO decrement, strobe and mu. The NCO advances only on consumed samples, and the
  // strobe is forced low in every other cycle.
  always_comb begin
    eta_d    = eta_q;
    strobe_d = 1'b0;
    mu_d     = mu_q;
    if (sample_valid) begin
      eta_d    = eta_q - step;
      strobe_d = underflow;
      if (underflow) mu_d = mu_new;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ_q  <= '0;
      ctrl_q   <= '0;
      eta_q    <= ETA_INIT;
      mu_q     <= '0;
      strobe_q <= 1'b0;
    end else begin
      integ_q  <= integ_d;
      ctrl_q   <= ctrl_d;
      eta_q    <= eta_d;
      mu_q     <= mu_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe    = strobe_q;
  assign mu        = mu_q;
  assign ctrl_word = ctrl_q;

endmodule

// File: tb/tb_gardner_loop_nco.sv
// Testbench for gardner_loop_nco: hand-computed vector table, model-driven random and
// long-run phases, and an asynchronous reset in the middle of the run.
module tb_gardner_loop_nco;

  logic        clk;
  logic        rst;
  logic        err_valid;
  logic [15:0] err_data;
  logic        sample_valid;
  logic        loop_clr;
  logic        strobe;
  logic [13:0] mu;
  logic [19:0] ctrl_word;

  gardner_loop_nco dut (
    .clk          (clk),
    .rst          (rst),
    .err_valid    (err_valid),
    .err_data     (err_data),
    .sample_valid (sample_valid),
    .loop_clr     (loop_clr),
    .strobe       (strobe),
    .mu           (mu),
    .ctrl_word    (ctrl_word)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];

  // Reference model state
  longint m_integ, m_ctrl;
  int     m_eta, m_mu;
  bit     m_strobe;

  function automatic longint fix_acc(longint x);
`ifdef GARDNER_LOOP_INTEG_SAT_EN
    if (x > 524287)  return 524287;
    if (x < -524288) return -524288;
    return x;
`else
    longint r;
    r = x & 64'hFFFFF;
    if (r >= 524288) r = r - 1048576;
    return r;
`endif
  endfunction

  task automatic model_reset();
    m_integ = 0; m_ctrl = 0; m_eta = 'hFFFF; m_mu = 0; m_strobe = 0;
  endtask

  task automatic model_step(input bit ev, input logic [15:0] ed, input bit sv, input bit lc);
    longint e, st, in;
    e  = $signed(ed);
    st = 32768 + m_ctrl * 4;
    if (st < 1)     st = 1;
    if (st > 65535) st = 65535;
    m_strobe = 0;
    if (sv) begin
      if (m_eta < st) begin
        m_strobe = 1;
        if (m_eta * 2 > 65535) m_mu = 'h3FFF;
        else                   m_mu = (m_eta * 2) / 4;
      end
      m_eta = int'((m_eta - st) & 'hFFFF);
    end
    if (lc) begin
      m_integ = 0; m_ctrl = 0;
    end else if (ev) begin
      in      = fix_acc(m_integ + (e >>> 10));
      m_ctrl  = fix_acc((e >>> 4) + in);
      m_integ = in;
    end
  endtask

  function automatic logic [34:0] model_exp();
    return {1'(m_strobe), 14'(m_mu), 20'(m_ctrl)};
  endfunction

  task automatic compare(input string name, input logic [34:0] exp);
    logic [34:0] got;
    got = {strobe, mu, ctrl_word};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got strobe=%0d mu=%h ctrl=%h, expected strobe=%0d mu=%h ctrl=%h",
               name, got[34], got[33:20], got[19:0], exp[34], exp[33:20], exp[19:0]);
    end
  endtask

  // Driver: apply one cycle of stimulus, queue its expectation, and check after the edge.
  task automatic cycle(input bit ev, input logic [15:0] ed, input bit sv, input bit lc,
                       input bit use_tbl, input logic [34:0] tbl_exp, input string name);
    err_valid = ev; err_data = ed; sample_valid = sv; loop_clr = lc;
    model_step(ev, ed, sv, lc);
    exp_q.push_back(use_tbl ? tbl_exp : model_exp());
    @(posedge clk);
    #1;
    compare(name, exp_q.pop_front());
  endtask

  typedef struct {
    bit          ev;
    logic [15:0] ed;
    bit          sv;
    bit          lc;
    bit          st;
    logic [13:0] mu;
    logic [19:0] ctrl;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Hand-derived expectations, starting from reset (eta=FFFF, ctrl=0).
    tbl[0]  = '{0, 16'h0000, 1, 0, 0, 14'h0000, 20'h00000}; // eta -> 7FFF
    tbl[1]  = '{0, 16'h0000, 1, 0, 1, 14'h3FFF, 20'h00000}; // underflow, eta -> FFFF
    tbl[2]  = '{0, 16'h0000, 1, 0, 0, 14'h3FFF, 20'h00000}; // eta -> 7FFF
    tbl[3]  = '{0, 16'h0000, 0, 0, 0, 14'h3FFF, 20'h00000}; // idle, no strobe
    tbl[4]  = '{0, 16'h0000, 1, 0, 1, 14'h3FFF, 20'h00000}; // eta -> FFFF
    tbl[5]  = '{1, 16'h2000, 1, 0, 0, 14'h3FFF, 20'h00208}; // old step 8000: eta -> 7FFF
    tbl[6]  = '{0, 16'h0000, 1, 0, 1, 14'h3FFF, 20'h00208}; // step 8820: eta -> F7DF
    tbl[7]  = '{0, 16'h0000, 1, 0, 0, 14'h3FFF, 20'h00208}; // eta -> 6FBF
    tbl[8]  = '{0, 16'h0000, 1, 0, 1, 14'h37DF, 20'h00208}; // eta -> E79F
    tbl[9]  = '{1, 16'h2000, 1, 1, 0, 14'h37DF, 20'h00000}; // clear wins, eta -> 5F7F
    tbl[10] = '{1, 16'h2000, 0, 0, 0, 14'h37DF, 20'h00208}; // integ restarted from 0
    tbl[11] = '{0, 16'h0000, 1, 0, 1, 14'h2FBF, 20'h00208}; // eta -> D75F
    tbl[12] = '{1, 16'hE000, 0, 0, 0, 14'h2FBF, 20'hFFE00}; // integ 0, ctrl -512
    tbl[13] = '{1, 16'hFFFF, 0, 0, 0, 14'h2FBF, 20'hFFFFE}; // -1>>>k = -1: integ -1, ctrl -2
    tbl[14] = '{0, 16'h0000, 0, 1, 0, 14'h2FBF, 20'h00000}; // clear alone

    rst = 1'b1; err_valid = 0; err_data = '0; sample_valid = 0; loop_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare("reset", 35'd0);
    #2 rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 15; i++)
      cycle(tbl[i].ev, tbl[i].ed, tbl[i].sv, tbl[i].lc, 1'b1,
            {tbl[i].st, tbl[i].mu, tbl[i].ctrl}, $sformatf("vec%0d", i));

    // Random traffic checked against the model
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) == 0, 16'($urandom_range(0, 65535)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, 1'b0, '0, "random");

    // Long run of maximum positive error pushes the integrator past its range
    cycle(0, 16'h0000, 1, 1, 1'b0, '0, "pre_long_clr");
    for (int i = 0; i < 16913; i++)
      cycle(1, 16'h7FFF, $urandom_range(0, 1) == 1, 0, 1'b0, '0, "long_run");
    checks++;
`ifdef GARDNER_LOOP_INTEG_SAT_EN
    if (ctrl_word !== 20'h7FFFF) begin
      errors++;
      $display("FAIL long_run_ctrl: got %h, expected %h", ctrl_word, 20'h7FFFF);
    end
`else
    if (ctrl_word !== 20'h8080E) begin
      errors++;
      $display("FAIL long_run_ctrl: got %h, expected %h", ctrl_word, 20'h8080E);
    end
`endif
    // Samples at the clamped step
    for (int i = 0; i < 20; i++)
      cycle(0, 16'h0000, 1, 0, 1'b0, '0, "clamped_step");

    // Asynchronous reset between clock edges
    err_valid = 0; sample_valid = 0; loop_clr = 0;
    #2 rst = 1'b1;
    #1 compare("async_reset", 35'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    cycle(0, 16'h0000, 1, 0, 1'b1, {1'b0, 14'h0000, 20'h00000}, "post_rst_s1");
    cycle(0, 16'h0000, 1, 0, 1'b1, {1'b1, 14'h3FFF, 20'h00000}, "post_rst_s2");
    cycle(0, 16'h0000, 1, 0, 1'b1, {1'b0, 14'h3FFF, 20'h00000}, "post_rst_s3");

    // Final report
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gardner_loop_nco.md
Name: gardner_loop_nco

Overview:
- Timing-recovery stage directly downstream of the Gardner timing-error detector in the symbol-sync loop.
- A proportional-integral loop filter turns each error sample into a control word.
- An NCO runs at the interpolator sample rate and adjusts its step by that control word.
- At each NCO underflow it pulses a symbol strobe and issues the fractional interval mu. The interpolator and the error detector's data_ready are driven from that strobe.

Parameters:
- SYM_WIDTH, 1, sign bits of error word
- INT_WIDTH, 1, integer bits of error word
- DEC_WIDTH, 14, fractional bits of error word and of mu
- ACC_WIDTH, 20, loop-filter integrator/control word width (signed, DEC_WIDTH fractional bits)
- NCO_WIDTH, 16, NCO register width (unsigned, all bits fractional, range [0,1)); must be >= DEC_WIDTH
- K1_SHIFT, 4, proportional gain = 2^-K1_SHIFT
- K2_SHIFT, 10, integral gain = 2^-K2_SHIFT
- NOM_STEP, 16'h8000, nominal NCO step (0.5 = 2 samples/symbol)
- ETA_INIT, 16'hFFFF, NCO reset value
- MU_SHIFT, 1, mu = eta * 2^MU_SHIFT (approximates eta/NOM_STEP)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- err_valid  in  1  error sample valid (from detector data_valid)
- err_data  in  SYM_WIDTH+INT_WIDTH+DEC_WIDTH  signed timing error
- sample_valid  in  1  one interpolator sample consumed this cycle
- loop_clr  in  1  synchronous clear of loop filter
- strobe  out  1  symbol strobe, one-cycle pulse
- mu  out  DEC_WIDTH  fractional interval, unsigned Q0.DEC_WIDTH
- ctrl_word  out  ACC_WIDTH  current loop-filter output (signed)

Behaviour:
- Reset (rst high, async): integ=0, ctrl_word=0, eta=ETA_INIT, strobe=0, mu=0.
- Loop filter updates only when err_valid=1:
  - e = sign-extended err_data.
  - integ_n = integ + (e>>>K2_SHIFT).
  - ctrl_word <= (e>>>K1_SHIFT) + integ_n.
  - integ <= integ_n.
  - Latency 1 cycle; registers hold otherwise.
- loop_clr=1: integ and ctrl_word become 0 next cycle. Overrides a simultaneous err_valid. NCO is unaffected.
- Step:
  - step = NOM_STEP + (ctrl_word <<< (NCO_WIDTH-DEC_WIDTH)).
  - Computed at ACC_WIDTH+NCO_WIDTH-DEC_WIDTH+1 bits signed.
  - Clamped to [1, 2^NCO_WIDTH-1].
- NCO advances only on sample_valid=1:
  - underflow = (eta < step).
  - eta <= (eta - step) mod 2^NCO_WIDTH.
- Strobe and mu on sample_valid:
  - strobe <= underflow, registered: appears the cycle after sample_valid.
  - On underflow: mu <= top DEC_WIDTH bits of (eta << MU_SHIFT) at NCO_WIDTH bits, where eta is the pre-update value. If any bit is shifted out, mu saturates to all-ones.
  - mu holds between underflows.
  - strobe=0 in every cycle without sample_valid.
- Simultaneous err_valid and sample_valid: the NCO uses the ctrl_word value held before this cycle's update.
- Integrator overflow wraps (two's complement) unless the optional feature is enabled.
- All arithmetic is two's complement; >>> is arithmetic and truncates toward -inf.

Optional Feature:
- Macro: GARDNER_LOOP_INTEG_SAT_EN.
- Defined: integ_n and ctrl_word saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- Undefined: both wrap modulo 2^ACC_WIDTH.

Test Plan:
- Reset, then sample_valid every cycle, err_valid=0: eta goes FFFF→7FFF→FFFF→…; strobe on every 2nd sample (one cycle after it); mu=0x3FFF; ctrl_word=0.
- One err_valid with err_data=0x2000: next cycle ctrl_word=0x00208, integ=0x8; subsequent step=0x8820; strobe spacing shortens accordingly.
- err_valid and sample_valid in the same cycle with a prior ctrl_word=0: that NCO update uses step 0x8000; the next sample uses the new step.
- loop_clr asserted together with err_valid=1, err_data=0x2000, after prior nonzero integ: ctrl_word=0 and integ=0 next cycle; eta sequence is not disturbed.
- err_data=0x7FFF held for 16913 updates:
  - With GARDNER_LOOP_INTEG_SAT_EN: integ=0x7FFFF.
  - Without: integ=0x8000F (wrapped).
- Async rst pulse mid-run, between clock edges: all outputs are 0 and eta=ETA_INIT immediately. The first strobe comes on the 2nd sample_valid after release.
